// File: rtl/m2m_pkg.sv
// ---------------------------------------------------------------------------
// m2m_pkg
// Shared definitions for the memory-to-memory transfer block: default data
// width and memory depths, plus the address types derived from them. Used by
// the datapath top level and by the controller that drives its strobes.
// ---------------------------------------------------------------------------
package m2m_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH_A = 8;
    localparam int DEF_DEPTH_B = 4;

    localparam int DEF_AW_A = $clog2(DEF_DEPTH_A);
    localparam int DEF_AW_B = $clog2(DEF_DEPTH_B);

    typedef logic [DEF_AW_A-1:0]   addr_a_t;
    typedef logic [DEF_AW_B-1:0]   addr_b_t;
    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage : m2m_pkg

// File: rtl/wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Free-running address counter that advances by one on each rising edge with
// inc high and wraps naturally from all-ones back to zero.
//
// Ports:
//   clock  in   system clock, rising edge
//   Reset  in   asynchronous active-high clear
//   inc    in   advance the count this edge
//   count  out  current count, WIDTH bits
// ---------------------------------------------------------------------------
module wrap_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs, regardless of block ordering.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (inc) begin
            // Width-limited add: all-ones + 1 wraps to zero by construction.
            count <= count + 1'b1;
        end
    end

endmodule : wrap_counter

// File: rtl/m2m_datapath.sv
// ---------------------------------------------------------------------------
// m2m_datapath
// Datapath responder for the memory-to-memory transfer controller. Holds the
// source memory A and destination memory B, one address counter for each,
// the previous-word register PrevA, an adder and an unsigned comparator.
// The controller strobes the counters and write enables; this block returns
// the status flags it sequences on.
//
// Ports:
//   clock    in   system clock, rising edge
//   Reset    in   asynchronous active-high reset (clears memories too)
//   IncA     in   advance AddrA and capture DOut1 into PrevA
//   IncB     in   advance AddrB
//   WEA      in   write DataInA into memory A at AddrA
//   WEB      in   write Sum into memory B at AddrB
//   DataInA  in   external load data for memory A
//   AddrA    out  memory A address
//   AddrB    out  memory B address
//   DOut1    out  memory A word at AddrA (combinational read)
//   DOut2    out  memory B word at AddrB (combinational read)
//   PrevA    out  word that memory A last stepped away from
//   Sum      out  PrevA + DOut1, carry dropped
//   AgtB     out  PrevA > DOut1, unsigned
//   LastA    out  AddrA is the final word of memory A
//   LastB    out  AddrB is the final word of memory B
// ---------------------------------------------------------------------------
module m2m_datapath
    import m2m_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH_A = DEF_DEPTH_A,
    parameter int DEPTH_B = DEF_DEPTH_B
) (
    input  logic                        clock,
    input  logic                        Reset,
    input  logic                        IncA,
    input  logic                        IncB,
    input  logic                        WEA,
    input  logic                        WEB,
    input  logic [DATA_W-1:0]           DataInA,
    output logic [$clog2(DEPTH_A)-1:0]  AddrA,
    output logic [$clog2(DEPTH_B)-1:0]  AddrB,
    output logic [DATA_W-1:0]           DOut1,
    output logic [DATA_W-1:0]           DOut2,
    output logic [DATA_W-1:0]           PrevA,
    output logic [DATA_W-1:0]           Sum,
    output logic                        AgtB,
    output logic                        LastA,
    output logic                        LastB
);

    localparam int AW_A = $clog2(DEPTH_A);
    localparam int AW_B = $clog2(DEPTH_B);

    logic [DATA_W-1:0] mem_a [DEPTH_A];
    logic [DATA_W-1:0] mem_b [DEPTH_B];

    // -----------------------------------------------------------------------
    // Address counters
    // -----------------------------------------------------------------------
    wrap_counter #(.WIDTH(AW_A)) u_cnt_a (
        .clock (clock),
        .Reset (Reset),
        .inc   (IncA),
        .count (AddrA)
    );

    wrap_counter #(.WIDTH(AW_B)) u_cnt_b (
        .clock (clock),
        .Reset (Reset),
        .inc   (IncB),
        .count (AddrB)
    );

    // -----------------------------------------------------------------------
    // Memories. The write uses the pre-edge address, so a write paired with
    // an increment lands at the old location before the counter moves.
    // -----------------------------------------------------------------------
    // NOTE: both memories must read as zero straight out of reset, so they
    // are built from resettable flops rather than an inferred RAM macro.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH_A; i++) begin
                mem_a[i] <= '0;
            end
        end else if (WEA) begin
            mem_a[AddrA] <= DataInA;
        end
    end

    // Sum here is the pre-edge value, i.e. built from the old DOut1 even when
    // memory A is being overwritten on the same edge.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH_B; i++) begin
                mem_b[i] <= '0;
            end
        end else if (WEB) begin
            mem_b[AddrB] <= Sum;
        end
    end

    // -----------------------------------------------------------------------
    // Previous-word register: captures the word being stepped away from,
    // which is the pre-write contents if WEA fires on the same edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            PrevA <= '0;
        end else if (IncA) begin
            PrevA <= DOut1;
        end
    end

    // -----------------------------------------------------------------------
    // Combinational read ports and status
    // -----------------------------------------------------------------------
    assign DOut1 = mem_a[AddrA];
    assign DOut2 = mem_b[AddrB];
    assign Sum   = PrevA + DOut1;   // same-width add, carry discarded
    assign AgtB  = (PrevA > DOut1);
    assign LastA = (AddrA == AW_A'(DEPTH_A - 1));
    assign LastB = (AddrB == AW_B'(DEPTH_B - 1));

endmodule : m2m_datapath

// File: tb/tb_m2m_datapath.sv
// ---------------------------------------------------------------------------
// tb_m2m_datapath
// Directed bench for m2m_datapath at default parameters (8-bit words,
// memory A 8 deep, memory B 4 deep). Inputs change 1 ns after a rising edge
// and outputs are sampled at that point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_m2m_datapath;

    import m2m_pkg::*;

    logic    clock = 1'b0;
    logic    Reset;
    logic    IncA, IncB, WEA, WEB;
    word_t   DataInA;
    addr_a_t AddrA;
    addr_b_t AddrB;
    word_t   DOut1, DOut2, PrevA, Sum;
    logic    AgtB, LastA, LastB;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    m2m_datapath dut (
        .clock   (clock),
        .Reset   (Reset),
        .IncA    (IncA),
        .IncB    (IncB),
        .WEA     (WEA),
        .WEB     (WEB),
        .DataInA (DataInA),
        .AddrA   (AddrA),
        .AddrB   (AddrB),
        .DOut1   (DOut1),
        .DOut2   (DOut2),
        .PrevA   (PrevA),
        .Sum     (Sum),
        .AgtB    (AgtB),
        .LastA   (LastA),
        .LastB   (LastB)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_strobes();
        IncA = 1'b0;
        IncB = 1'b0;
        WEA  = 1'b0;
        WEB  = 1'b0;
    endtask

    word_t load_vals [8] = '{8'd5, 8'd3, 8'd9, 8'd9, 8'd1, 8'd7, 8'd200, 8'd100};

    initial begin
        // ---------------- Reset state ----------------
        // Strobes held high under reset: reset must dominate them.
        Reset   = 1'b1;
        IncA    = 1'b1;
        IncB    = 1'b1;
        WEA     = 1'b1;
        WEB     = 1'b1;
        DataInA = word_t'($urandom);
        #1;
        check("rst_addra_async", 32'(AddrA), 32'd0);
        step();
        check("rst_addra", 32'(AddrA), 32'd0);
        check("rst_addrb", 32'(AddrB), 32'd0);
        check("rst_prev",  32'(PrevA), 32'd0);
        check("rst_dout1", 32'(DOut1), 32'd0);
        check("rst_dout2", 32'(DOut2), 32'd0);
        check("rst_sum",   32'(Sum),   32'd0);
        check("rst_agtb",  32'(AgtB),  32'd0);
        check("rst_lasta", 32'(LastA), 32'd0);
        check("rst_lastb", 32'(LastB), 32'd0);
        idle_strobes();
        Reset = 1'b0;
        step();
        check("post_rst_addra", 32'(AddrA), 32'd0);

        // ---------------- 1. Load A with WEA+IncA, then read back ----------------
        for (int i = 0; i < 8; i++) begin
            DataInA = load_vals[i];
            WEA     = 1'b1;
            IncA    = 1'b1;
            check($sformatf("load_addr%0d", i), 32'(AddrA), 32'(i));
            check($sformatf("load_last%0d", i), 32'(LastA), (i == 7) ? 32'd1 : 32'd0);
            step();
        end
        idle_strobes();
        check("load_wrap_addra", 32'(AddrA), 32'd0);
        check("load_wrap_lasta", 32'(LastA), 32'd0);
        // Each load edge captured the pre-write word (all zero) into PrevA.
        check("load_prev", 32'(PrevA), 32'd0);

        for (int i = 0; i < 8; i++) begin
            check($sformatf("readback%0d", i), 32'(DOut1), 32'(load_vals[i]));
            IncA = 1'b1;
            step();
        end
        IncA = 1'b0;
        check("readback_prev", 32'(PrevA), 32'd100);
        check("readback_addra", 32'(AddrA), 32'd0);

        // ---------------- 2. Compare flag and sum ----------------
        IncA = 1'b1;
        step();                                   // PrevA=5, AddrA=1, DOut1=3
        check("cmp1_prev", 32'(PrevA), 32'd5);
        check("cmp1_dout", 32'(DOut1), 32'd3);
        check("cmp1_agtb", 32'(AgtB),  32'd1);
        check("cmp1_sum",  32'(Sum),   32'd8);
        step();                                   // PrevA=3, DOut1=9
        check("cmp2_agtb", 32'(AgtB),  32'd0);
        check("cmp2_sum",  32'(Sum),   32'd12);
        step();                                   // PrevA=9, DOut1=9
        check("cmp_eq_agtb", 32'(AgtB), 32'd0);
        check("cmp_eq_sum",  32'(Sum),  32'd18);
        for (int i = 0; i < 4; i++) step();       // AddrA 3 -> 7
        IncA = 1'b0;
        check("ovf_addra", 32'(AddrA), 32'd7);
        check("ovf_prev",  32'(PrevA), 32'd200);
        check("ovf_dout1", 32'(DOut1), 32'd100);
        check("ovf_agtb",  32'(AgtB),  32'd1);
        check("ovf_sum",   32'(Sum),   32'd44);

        // ---------------- 3. Overflow write into B[3] ----------------
        IncB = 1'b1;
        step();
        step();
        check("b_addr2_lastb", 32'(LastB), 32'd0);
        step();
        IncB = 1'b0;
        check("b_addr3", 32'(AddrB), 32'd3);
        check("b_addr3_lastb", 32'(LastB), 32'd1);
        check("b_pre_dout2", 32'(DOut2), 32'd0);
        WEB = 1'b1;
        step();
        WEB = 1'b0;
        check("ovf_dout2", 32'(DOut2), 32'd44);
        check("ovf_addrb_hold", 32'(AddrB), 32'd3);
        check("ovf_lastb_hold", 32'(LastB), 32'd1);

        // ---------------- 4. WEB+IncB at AddrB=3 ----------------
        IncA = 1'b1;
        step();                                   // AddrA 7->0, PrevA=100, DOut1=5
        IncA = 1'b0;
        check("wi_sum", 32'(Sum), 32'd105);
        WEB  = 1'b1;
        IncB = 1'b1;
        step();
        WEB  = 1'b0;
        check("wi_addrb_wrap", 32'(AddrB), 32'd0);
        check("wi_lastb", 32'(LastB), 32'd0);
        check("wi_dout2_b0", 32'(DOut2), 32'd0);
        step();
        step();
        step();
        IncB = 1'b0;
        check("wi_addrb3", 32'(AddrB), 32'd3);
        check("wi_dout2_b3", 32'(DOut2), 32'd105);

        // ---------------- 5. WEA+WEB on the same edge ----------------
        DataInA = 8'd1;
        WEA     = 1'b1;
        step();                                   // memA[0]=1
        WEA  = 1'b0;
        check("ww_same_cycle_dout1", 32'(DOut1), 32'd1);
        IncA = 1'b1;
        step();                                   // PrevA=1, AddrA=1
        IncA    = 1'b0;
        DataInA = 8'd4;
        WEA     = 1'b1;
        step();                                   // memA[1]=4
        check("ww_prev", 32'(PrevA), 32'd1);
        check("ww_dout1", 32'(DOut1), 32'd4);
        check("ww_sum", 32'(Sum), 32'd5);
        DataInA = 8'hFF;
        WEA     = 1'b1;
        WEB     = 1'b1;
        step();
        idle_strobes();
        check("ww_memb", 32'(DOut2), 32'd5);
        check("ww_mema", 32'(DOut1), 32'hFF);
        check("ww_sum_after", 32'(Sum), 32'd0);
        check("ww_agtb_after", 32'(AgtB), 32'd0);

        // ---------------- 6. Asynchronous reset mid-operation ----------------
        IncA = 1'b1;
        step();                                   // AddrA=2, PrevA=FF
        check("mr_pre_addra", 32'(AddrA), 32'd2);
        check("mr_pre_prev", 32'(PrevA), 32'hFF);
        #2;
        Reset = 1'b1;
        #1;
        check("mr_addra", 32'(AddrA), 32'd0);
        check("mr_prev",  32'(PrevA), 32'd0);
        check("mr_dout1", 32'(DOut1), 32'd0);
        check("mr_dout2", 32'(DOut2), 32'd0);
        check("mr_addrb", 32'(AddrB), 32'd0);
        #1;
        Reset = 1'b0;
        step();                                   // IncA still high
        IncA = 1'b0;
        check("mr_resume_addra", 32'(AddrA), 32'd1);
        check("mr_resume_prev",  32'(PrevA), 32'd0);
        check("mr_resume_dout1", 32'(DOut1), 32'd0);  // memA[1] was 0xFF before reset

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_m2m_datapath
